// File: rtl/dac_pkg.sv
// Shared definitions for the PmodDA2 (DAC121S101) serial transmitter.
// Contents: FSM state type, frame/code widths, power-down field value, and the
// sample-to-code reduction used at accept time.
// Build option: define DAC_ROUND_EN to round half-up (with clip) instead of truncating.
package dac_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CODE_W  = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    // 16-bit unsigned mixer sample -> 12-bit DAC code.
    function automatic logic [CODE_W-1:0] sample_to_code(input logic [FRAME_W-1:0] s);
`ifdef DAC_ROUND_EN
        logic [CODE_W:0] sum;
        logic            unused_lsbs;
        unused_lsbs = ^s[2:0];
        sum = {1'b0, s[15:4]} + {{CODE_W{1'b0}}, s[3]};
        // Carry out only happens from 12'hFFF + 1: clip to full scale.
        return sum[CODE_W] ? {CODE_W{1'b1}} : sum[CODE_W-1:0];
`else
        logic unused_lsbs;
        unused_lsbs = ^s[3:0];
        return s[15:4];
`endif
    endfunction

    // Frame layout: {2 don't-care, 2 power-down, 12 code}, sent MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [CODE_W-1:0] code);
        return {2'b00, PD_NORMAL, code};
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample handshake plus DAC pin bundle for dac_spi_tx.
// master: upstream sample source view. slave: the transmitter view.
// Signals: sample_in/sample_valid/sample_ready handshake, busy status,
// dac_sync_n/dac_sclk/dac_din serial pins.
interface dac_spi_tx_if;

    logic [dac_pkg::FRAME_W-1:0] sample_in;
    logic                        sample_valid;
    logic                        sample_ready;
    logic                        busy;
    logic                        dac_sync_n;
    logic                        dac_sclk;
    logic                        dac_din;

    modport master (
        output sample_in, sample_valid,
        input  sample_ready, busy, dac_sync_n, dac_sclk, dac_din
    );

    modport slave (
        input  sample_in, sample_valid,
        output sample_ready, busy, dac_sync_n, dac_sclk, dac_din
    );

endinterface

// File: rtl/dac_spi_tx_sclk_div.sv
// SCLK half-period timer. Emits a one-cycle phase_tick on the last system clock
// of every CLK_DIV-clock half-period; restarts on rst and on clear (sample accept).
// Ports: clk, rst (sync, active-high), clear, phase_tick.
module sclk_div #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic phase_tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign phase_tick = (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (phase_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serial transmitter for a DAC121S101 (PmodDA2). Accepts one 16-bit sample per
// valid/ready handshake, reduces it to a 12-bit code and shifts a 16-bit frame out
// MSB first. Each bit is CLK_DIV clocks SCLK high then CLK_DIV clocks low; SYNC_n
// then stays high GAP_CYC clocks before the next sample can be accepted.
// Ports: clk, rst (sync, active-high), bus (dac_spi_tx_if.slave).
// Build option: DAC_ROUND_EN selects rounded code reduction (see dac_pkg).
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);

    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [4:0]           phase_q, phase_d;   // half-period index 0..31, even = SCLK high
    logic [GapW-1:0]      gap_q, gap_d;
    logic                 sync_n_q, sync_n_d;
    logic                 sclk_q, sclk_d;
    logic                 din_q, din_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 phase_tick;
    logic [FRAME_W-1:0]   frame_in;

    assign accept   = (state_q == StIdle) && ready_q && bus.sample_valid;
    assign frame_in = build_frame(sample_to_code(bus.sample_in));

    sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .phase_tick (phase_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        sync_n_d = sync_n_q;
        sclk_d   = sclk_q;
        din_d    = din_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StShift;
                    shift_d  = frame_in;
                    din_d    = frame_in[FRAME_W-1];
                    phase_d  = '0;
                    sync_n_d = 1'b0;
                    sclk_d   = 1'b1;
                end
            end
            StShift: begin
                if (phase_tick) begin
                    if (phase_q == 5'd31) begin
                        state_d  = StGap;
                        gap_d    = '0;
                        sync_n_d = 1'b1;
                        sclk_d   = 1'b1;
                        din_d    = 1'b0;
                    end else begin
                        phase_d = phase_q + 5'd1;
                        if (!phase_q[0]) begin
                            sclk_d = 1'b0;          // falling edge: DAC samples din
                        end else begin
                            // Next bit is presented together with the rising edge.
                            sclk_d  = 1'b1;
                            din_d   = shift_q[FRAME_W-2];
                            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            phase_q  <= '0;
            gap_q    <= '0;
            sync_n_q <= 1'b1;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            phase_q  <= phase_d;
            gap_q    <= gap_d;
            sync_n_q <= sync_n_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.dac_sync_n   = sync_n_q;
    assign bus.dac_sclk     = sclk_q;
    assign bus.dac_din      = din_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=1/GAP_CYC=2 and CLK_DIV=3/GAP_CYC=3)
// share one stimulus stream; a cycle-level behavioural model predicts every output
// from time-since-accept arithmetic, plus literal checks on captured frames.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample;
    logic        valid;

    always #5 clk = ~clk;

    dac_spi_tx_if bus0 ();
    dac_spi_tx_if bus1 ();

    assign bus0.sample_in    = sample;
    assign bus0.sample_valid = valid;
    assign bus1.sample_in    = sample;
    assign bus1.sample_valid = valid;

    dac_spi_tx #(.CLK_DIV(1), .GAP_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    dac_spi_tx #(.CLK_DIV(3), .GAP_CYC(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic [1:0] o_sync, o_sclk, o_din, o_rdy, o_busy;
    assign o_sync = {bus1.dac_sync_n, bus0.dac_sync_n};
    assign o_sclk = {bus1.dac_sclk, bus0.dac_sclk};
    assign o_din  = {bus1.dac_din, bus0.dac_din};
    assign o_rdy  = {bus1.sample_ready, bus0.sample_ready};
    assign o_busy = {bus1.busy, bus0.busy};

`ifdef DAC_ROUND_EN
    localparam logic [15:0] WordAbc8 = 16'h0ABD;
`else
    localparam logic [15:0] WordAbc8 = 16'h0ABC;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic int cdv(int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic int gpv(int l);
        return (l == 0) ? 2 : 3;
    endfunction

    function automatic int code_of(logic [15:0] s);
        int c;
        c = int'(s) / 16;
`ifdef DAC_ROUND_EN
        c = c + (int'(s) / 8) % 2;
        if (c > 4095) c = 4095;
`endif
        return c;
    endfunction

    task automatic chk(string name, int l, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s lane%0d cyc=%0d got=%0h want=%0h", name, l, cyc, act, exp);
        end
    endtask

    // Behavioural model: mode -1 unknown, 0 reset values, 1 idle/ready, 2 in frame at t.
    int m_mode[2] = '{-1, -1};
    int m_t[2];
    int m_code[2];

    always @(negedge clk) begin
        int e_sync, e_sclk, e_din, e_rdy, e_busy, k, l2;
        cyc++;
        for (int l = 0; l < 2; l++) begin
            if (m_mode[l] >= 0) begin
                e_sync = 1; e_sclk = 1; e_din = 0; e_rdy = 0; e_busy = 0;
                if (m_mode[l] == 1) e_rdy = 1;
                if (m_mode[l] == 2) begin
                    e_busy = 1;
                    l2 = 2 * cdv(l);
                    if (m_t[l] < 16 * l2) begin
                        k      = 15 - m_t[l] / l2;
                        e_sync = 0;
                        e_sclk = ((m_t[l] % l2) < cdv(l)) ? 1 : 0;
                        e_din  = (m_code[l] >> k) & 1;
                    end
                end
                chk("sync_n", l, int'(o_sync[l]), e_sync);
                chk("sclk", l, int'(o_sclk[l]), e_sclk);
                chk("din", l, int'(o_din[l]), e_din);
                chk("ready", l, int'(o_rdy[l]), e_rdy);
                chk("busy", l, int'(o_busy[l]), e_busy);
            end
            if (rst) begin
                m_mode[l] = 0;
            end else begin
                case (m_mode[l])
                    0: m_mode[l] = 1;
                    1: if (valid) begin
                        m_mode[l] = 2;
                        m_t[l]    = 0;
                        m_code[l] = code_of(sample);
                    end
                    2: begin
                        m_t[l]++;
                        if (m_t[l] == 32 * cdv(l) + gpv(l)) m_mode[l] = 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame capture: din at each SCLK falling edge while SYNC_n is low.
    logic [15:0] word[2];
    logic [15:0] last_word[2];
    int          nedge[2] = '{0, 0};
    int          last_nedge[2] = '{0, 0};
    int          hi_cnt[2] = '{0, 0};
    int          hi_run[2] = '{0, 0};
    logic [1:0]  prev_sclk = 2'b11;
    logic [1:0]  prev_sync = 2'b11;
    logic [15:0] wq0[$];

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!o_sync[l] && prev_sclk[l] && !o_sclk[l]) begin
                word[l] = {word[l][14:0], o_din[l]};
                nedge[l]++;
            end
            if (o_sync[l] && !prev_sync[l]) begin
                last_word[l]  = word[l];
                last_nedge[l] = nedge[l];
                if (l == 0) wq0.push_back(word[l]);
            end
            if (o_sync[l]) begin
                hi_cnt[l]++;
                nedge[l] = 0;
                word[l]  = '0;
            end else begin
                if (prev_sync[l]) hi_run[l] = hi_cnt[l];
                hi_cnt[l] = 0;
            end
        end
        prev_sclk = o_sclk;
        prev_sync = o_sync;
    end

    int acc_cyc[2];
    int rdy_cyc[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic [1:0] seen;
        seen = 2'b00;
        for (int n = 0; n < 400 && seen != 2'b11; n++) begin
            for (int l = 0; l < 2; l++) begin
                if (o_rdy[l] && !seen[l]) begin
                    seen[l]    = 1'b1;
                    rdy_cyc[l] = cyc;
                end
            end
            if (seen != 2'b11) tick();
        end
        if (seen != 2'b11) chk("idle_timeout", 0, int'(seen), 3);
    endtask

    // Offer a sample until both lanes take it, then check timing and frame content.
    task automatic send(logic [15:0] s);
        logic [1:0] got;
        got    = 2'b00;
        sample = s;
        valid  = 1'b1;
        for (int n = 0; n < 400 && got != 2'b11; n++) begin
            for (int l = 0; l < 2; l++) begin
                if (o_rdy[l] && !got[l]) begin
                    got[l]     = 1'b1;
                    acc_cyc[l] = cyc;
                end
            end
            tick();
        end
        valid = 1'b0;
        if (got != 2'b11) chk("accept_timeout", 0, int'(got), 3);
        wait_idle();
        for (int l = 0; l < 2; l++) begin
            chk("ready_latency", l, rdy_cyc[l] - acc_cyc[l], 1 + 32 * cdv(l) + gpv(l));
            chk("frame_word", l, int'(last_word[l]), code_of(s));
            chk("frame_edges", l, last_nedge[l], 16);
        end
    endtask

    initial begin
        int n0acc, a1, a2, qs;
        rst    = 1'b1;
        valid  = 1'b1;
        sample = 16'hABC8;
        repeat (3) tick();
        chk("rst_ready", 0, int'(o_rdy), 0);
        chk("rst_busy", 0, int'(o_busy), 0);
        chk("rst_sync", 0, int'(o_sync), 3);
        rst = 1'b0;
        tick();
        chk("first_ready", 0, int'(o_rdy), 3);

        send(16'hABC8);
        chk("abc8_word", 0, int'(last_word[0]), int'(WordAbc8));
        chk("abc8_word", 1, int'(last_word[1]), int'(WordAbc8));
        send(16'hFFF8);
        chk("fff8_word", 0, int'(last_word[0]), 16'h0FFF);

        // Back-to-back on lane 0 with valid held high.
        qs     = wq0.size();
        n0acc  = 0;
        a1     = 0;
        a2     = 0;
        sample = 16'h1230;
        valid  = 1'b1;
        for (int n = 0; n < 200 && n0acc < 2; n++) begin
            if (o_rdy[0]) begin
                n0acc++;
                if (n0acc == 1) a1 = cyc; else a2 = cyc;
            end
            tick();
            if (n0acc == 1) sample = 16'h4560;
        end
        valid = 1'b0;
        chk("b2b_accepts", 0, n0acc, 2);
        chk("b2b_spacing", 0, a2 - a1, 35);
        wait_idle();
        chk("b2b_nframes", 0, wq0.size() - qs, 2);
        if (wq0.size() >= qs + 2) begin
            chk("b2b_word1", 0, int'(wq0[qs]), 16'h0123);
            chk("b2b_word2", 0, int'(wq0[qs+1]), 16'h0456);
        end
        // GAP_CYC clocks of gap plus the accept cycle keep SYNC_n high.
        chk("b2b_sync_high", 0, hi_run[0], gpv(0) + 1);

        // Reset during lane 0 bit-7 high phase (T1+16), both lanes aborted.
        sample = 16'(($urandom & 32'hFFFF));
        valid  = 1'b1;
        tick();
        valid = 1'b0;
        for (int n = 0; n < 100 && !(m_mode[0] == 2 && m_t[0] == 16); n++) tick();
        chk("reach_bit7", 0, m_t[0], 16);
        rst = 1'b1;
        tick();
        chk("abort_sync", 0, int'(o_sync), 3);
        chk("abort_sclk", 0, int'(o_sclk), 3);
        rst = 1'b0;
        tick();
        for (int l = 0; l < 2; l++)
            chk("abort_edges", l, last_nedge[l], (16 - cdv(l)) / (2 * cdv(l)) + 1);
        wait_idle();
        send(16'h5A5F);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            send(16'(($urandom & 32'hFFFF)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
